decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   Registered, parametrised RV32 instruction decode stage with a valid/ready handshake on both sides.
//   Sits between fetch and execute. Splits each 32-bit instruction into opcode, register indices and
//   funct fields. Classifies the instruction format and builds a single sign-extended immediate.
//   Buffers up to DEPTH decoded entries so fetch can run ahead of a stalled execute stage.
// PARAMETERS
//   XLEN    32  datapath width of out_imm and of in_pc/out_pc (32 or 64)
//   REG_AW  5   register index width; indices zero-extended from the 5-bit instruction fields
//   DEPTH   2   output buffer entries; power of two, >= 2
// PORTS
//   clk          in   1             rising-edge clock
//   rst_n        in   1             asynchronous active-low reset
//   flush        in   1             synchronous discard of all buffered entries
//   in_valid     in   1             in_instr/in_pc valid
//   in_ready     out  1             buffer can accept (not full)
//   in_instr     in   32            raw instruction word
//   in_pc        in   XLEN          PC of in_instr
//   out_valid    out  1             head entry valid
//   out_ready    in   1             consumer takes head entry
//   out_pc       out  XLEN          PC of head entry
//   out_opcode   out  7             instr[6:0]
//   out_rd/rs1/rs2 out REG_AW       instr[11:7] / [19:15] / [24:20], zero-extended
//   out_funct3   out  3             instr[14:12]
//   out_funct7   out  7             instr[31:25]
//   out_fmt      out  3             0=R 1=I 2=S 3=B 4=U 5=J 7=unknown
//   out_imm      out  XLEN          immediate for out_fmt, sign-extended; 0 for R or unknown
//   out_illegal  out  1             illegal flag (see CONFIGURATION)
//   count        out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//   - Reset (rst_n=0, async): buffer empty, count=0, out_valid=0, in_ready=1, all data outputs 0.
//   - Handshake:
//     - push when in_valid&&in_ready; pop when out_valid&&out_ready.
//     - in_ready = (count!=DEPTH). It is not combinationally dependent on out_ready: no pass-through when full.
//     - A push into an empty buffer gives out_valid=1 on the next cycle (latency 1).
//     - Decode is combinational on in_instr; decoded fields are stored, not recomputed at the output.
//   - Simultaneous push and pop (count neither 0 nor full): count unchanged, FIFO order kept.
//   - Head outputs:
//     - Hold stable while out_valid && !out_ready.
//     - When count=0, out_valid=0 and data outputs hold their last value.
//   - Pointers wrap modulo DEPTH.
//   - flush: next cycle count=0, out_valid=0. Flush beats a same-cycle push (entry dropped) and a same-cycle pop.
//   - Format by opcode:
//     - 0110011 -> R
//     - 0010011, 0000011, 1100111, 1110011 -> I
//     - 0100011 -> S
//     - 1100011 -> B
//     - 0110111, 0010111 -> U
//     - 1101111 -> J
//     - anything else -> 7
//   - Immediates, all sign-extended from instr[31] to XLEN:
//     - I: instr[31:20]
//     - S: {instr[31:25], instr[11:7]}
//     - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
//     - U: {instr[31:12], 12'b0}
//     - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
//   - Reset asserted mid-operation empties the buffer immediately; in-flight entries are lost.
// CONFIGURATION
//   DECODE_ILLEGAL_EN defined:
//     - out_illegal=1 when instr[1:0]!=2'b11, or fmt=7, or (fmt=R and funct7 not in {0x00,0x20}).
//     - Illegal entries still flow through the buffer normally.
//   DECODE_ILLEGAL_EN undefined: out_illegal is tied to 0. No checker logic is built.
// TESTING
//   - addi x1,x0,-1 (0xFFF00093) -> opcode 0x13, rd 1, rs1 0, fmt 1, imm 0xFFFFFFFF, out_valid 1 cycle after push
//   - sw x1,4(x2) (0x00112223) -> fmt 2, rs1 2, rs2 1, funct3 2, imm 4
//   - beq x0,x0,-4 (0xFE000EE3) -> fmt 3, imm 0xFFFFFFFC
//   - lui x5,0x12345 (0x123452B7) -> fmt 4, rd 5, imm 0x12345000
//   - jal x1,8 (0x008000EF) -> fmt 5, imm 8
//   - Backpressure: out_ready=0, push DEPTH words -> in_ready=0, count=DEPTH, head stable;
//     then out_ready=1 -> entries drain in push order
//   - Flush + reset:
//     - flush with a same-cycle push -> count=0 next cycle, pushed word never appears
//     - rst_n low mid-stream -> all outputs at reset values
//   - Illegal check: 0x00000000 -> out_illegal=1 with DECODE_ILLEGAL_EN, 0 without

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32 decode stage with valid/ready on both sides.
//
// Decodes in_instr combinationally into opcode, register indices, funct
// fields, format class and a sign-extended immediate. It then stores the
// decoded record in a DEPTH-entry FIFO so fetch can run ahead of a stalled
// execute stage. The output fields are read from the stored record and are
// never re-decoded.
//
// Optional build macro: DECODE_ILLEGAL_EN enables the illegal-instruction
// checker that drives out_illegal. Without the macro, out_illegal is 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous discard of every buffered entry
//   in_valid/in_ready   upstream handshake; in_instr/in_pc carried with it
//   out_valid/out_ready downstream handshake for the head entry
//   out_pc .. out_illegal  decoded fields of the head entry
//   count               current occupancy (0..DEPTH)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Once valid is asserted it is held with stable data until it is accepted.
// in_ready depends only on occupancy, never on out_ready, so a full buffer
// accepts nothing even in a cycle where the head is being popped.
module decode_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [6:0]                 out_opcode,
    output logic [REG_AW-1:0]          out_rd,
    output logic [REG_AW-1:0]          out_rs1,
    output logic [REG_AW-1:0]          out_rs2,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [2:0]                 out_fmt,
    output logic [XLEN-1:0]            out_imm,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_UNK = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [6:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [2:0]        fmt;
        logic [XLEN-1:0]   imm;
        logic              illegal;
    } entry_t;

    entry_t          dec;
    logic [31:0]     imm32;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          last_q, last_d;
    entry_t          head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    // Combinational decode of the incoming word.
    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.opcode = in_instr[6:0];
        dec.rd     = REG_AW'(in_instr[11:7]);
        dec.rs1    = REG_AW'(in_instr[19:15]);
        dec.rs2    = REG_AW'(in_instr[24:20]);
        dec.funct3 = in_instr[14:12];
        dec.funct7 = in_instr[31:25];
        case (in_instr[6:0])
            7'b0110011:                                     dec.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec.fmt = FMT_I;
            7'b0100011:                                     dec.fmt = FMT_S;
            7'b1100011:                                     dec.fmt = FMT_B;
            7'b0110111, 7'b0010111:                         dec.fmt = FMT_U;
            7'b1101111:                                     dec.fmt = FMT_J;
            default:                                        dec.fmt = FMT_UNK;
        endcase

        imm32 = '0;
        case (dec.fmt)
            FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32 = {in_instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Every 32-bit immediate already carries instr[31] in its MSB, so a
        // signed resize gives the sign extension to XLEN.
        dec.imm = XLEN'($signed(imm32));

`ifdef DECODE_ILLEGAL_EN
        dec.illegal = (in_instr[1:0] != 2'b11) || (dec.fmt == FMT_UNK) ||
                      ((dec.fmt == FMT_R) &&
                       (in_instr[31:25] != 7'h00) && (in_instr[31:25] != 7'h20));
`else
        dec.illegal = 1'b0;
`endif
    end

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // When the buffer is empty, the outputs show the last displayed record.
    // last_q follows the visible head every cycle, so it already holds
    // that record when the buffer drains or is flushed.
    assign head   = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign last_d = head;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Flush wins over any push or pop in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + 1'b1;   // wraps: DEPTH is a power of two
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_pc      = head.pc;
    assign out_opcode  = head.opcode;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_fmt     = head.fmt;
    assign out_imm     = head.imm;
    assign out_illegal = head.illegal;
    assign count       = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: a table of known encodings, hand-written
// multi-cycle sequences, and random traffic checked against a queue model.
module tb_decode_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk, rst_n, flush;
    logic              in_valid, in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid, out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [6:0]        out_opcode;
    logic [REG_AW-1:0] out_rd, out_rs1, out_rs2;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [2:0]        out_fmt;
    logic [XLEN-1:0]   out_imm;
    logic              out_illegal;
    logic [CW-1:0]     count;

    decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_fmt(out_fmt),
        .out_imm(out_imm), .out_illegal(out_illegal), .count(count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic [EW-1:0] exp_q[$];
    exp_t          last_shown;
    int            total = 0;
    int            bad   = 0;

    // Builds the immediate as an unsigned number of n bits from its pieces,
    // then applies two's-complement sign by subtracting 2^n.
    function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        logic [31:0] raw;
        int n;
        e = '0;
        e.pc = pc; e.opcode = instr[6:0];
        e.rd = instr[11:7]; e.rs1 = instr[19:15]; e.rs2 = instr[24:20];
        e.funct3 = instr[14:12]; e.funct7 = instr[31:25];
        case (instr[6:0])
            7'h33:                      e.fmt = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73: e.fmt = 3'd1;
            7'h23:                      e.fmt = 3'd2;
            7'h63:                      e.fmt = 3'd3;
            7'h37, 7'h17:               e.fmt = 3'd4;
            7'h6F:                      e.fmt = 3'd5;
            default:                    e.fmt = 3'd7;
        endcase
        raw = 0; n = 0;
        case (e.fmt)
            3'd1: begin raw = 32'(instr[31:20]); n = 12; end
            3'd2: begin raw = 32'(instr[31:25]) * 32 + 32'(instr[11:7]); n = 12; end
            3'd3: begin
                raw = 32'(instr[31]) * 4096 + 32'(instr[7]) * 2048 +
                      32'(instr[30:25]) * 32 + 32'(instr[11:8]) * 2;
                n = 13;
            end
            3'd4: begin raw = 32'(instr[31:12]) * 4096; n = 32; end
            3'd5: begin
                raw = 32'(instr[31]) * (32'd1 << 20) + 32'(instr[19:12]) * 4096 +
                      32'(instr[20]) * 2048 + 32'(instr[30:21]) * 2;
                n = 21;
            end
            default: begin raw = 0; n = 0; end
        endcase
        if (n > 0 && n < 32 && instr[31]) raw = raw - (32'd1 << n);
        e.imm = raw;
`ifdef DECODE_ILLEGAL_EN
        e.ill = (instr[1:0] != 2'b11) || (e.fmt == 3'd7) ||
                (e.fmt == 3'd0 && !(instr[31:25] == 7'h00 || instr[31:25] == 7'h20));
`else
        e.ill = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
        if (w[6:0] == 7'h33 && $urandom_range(0, 1) == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_head(input string tag, input exp_t e);
        check({tag, ".valid"},   64'(out_valid),   64'd1);
        check({tag, ".pc"},      64'(out_pc),      64'(e.pc));
        check({tag, ".opcode"},  64'(out_opcode),  64'(e.opcode));
        check({tag, ".rd"},      64'(out_rd),      64'(e.rd));
        check({tag, ".rs1"},     64'(out_rs1),     64'(e.rs1));
        check({tag, ".rs2"},     64'(out_rs2),     64'(e.rs2));
        check({tag, ".funct3"},  64'(out_funct3),  64'(e.funct3));
        check({tag, ".funct7"},  64'(out_funct7),  64'(e.funct7));
        check({tag, ".fmt"},     64'(out_fmt),     64'(e.fmt));
        check({tag, ".imm"},     64'(out_imm),     64'(e.imm));
        check({tag, ".illegal"}, 64'(out_illegal), 64'(e.ill));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic drive_push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  funct3;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill_en;
    } vec_t;
    vec_t vecs[7];

    logic [31:0] w_instr [DEPTH];
    exp_t        e;

    initial begin
        vecs[0] = '{32'hFFF00093, 7'h13, 5'd1,  5'd0, 5'd31, 3'd0, 3'd1, 32'hFFFFFFFF, 1'b0}; // addi x1,x0,-1
        vecs[1] = '{32'h00112223, 7'h23, 5'd4,  5'd2, 5'd1,  3'd2, 3'd2, 32'h00000004, 1'b0}; // sw x1,4(x2)
        vecs[2] = '{32'hFE000EE3, 7'h63, 5'd29, 5'd0, 5'd0,  3'd0, 3'd3, 32'hFFFFFFFC, 1'b0}; // beq x0,x0,-4
        vecs[3] = '{32'h123452B7, 7'h37, 5'd5,  5'd8, 5'd3,  3'd5, 3'd4, 32'h12345000, 1'b0}; // lui x5,0x12345
        vecs[4] = '{32'h008000EF, 7'h6F, 5'd1,  5'd0, 5'd8,  3'd0, 3'd5, 32'h00000008, 1'b0}; // jal x1,8
        vecs[5] = '{32'h002081B3, 7'h33, 5'd3,  5'd1, 5'd2,  3'd0, 3'd0, 32'h00000000, 1'b0}; // add x3,x1,x2
        vecs[6] = '{32'h00000000, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 3'd7, 32'h00000000, 1'b1}; // all zero

        drive_idle();
        in_instr = '0; in_pc = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.count",     64'(count),     64'd0);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.in_ready",  64'(in_ready),  64'd1);
        check("reset.out_pc",    64'(out_pc),    64'd0);
        check("reset.out_imm",   64'(out_imm),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: push one word, expect it at the head one cycle later, pop it.
        for (int i = 0; i < 7; i++) begin
            drive_push(vecs[i].instr, 32'h1000 + 32'(i * 4));
            @(negedge clk);
            in_valid = 1'b0;
            check("tbl.valid",  64'(out_valid),  64'd1);
            check("tbl.count1", 64'(count),      64'd1);
            check("tbl.pc",     64'(out_pc),     64'(32'h1000 + 32'(i * 4)));
            check("tbl.opcode", 64'(out_opcode), 64'(vecs[i].opcode));
            check("tbl.rd",     64'(out_rd),     64'(vecs[i].rd));
            check("tbl.rs1",    64'(out_rs1),    64'(vecs[i].rs1));
            check("tbl.rs2",    64'(out_rs2),    64'(vecs[i].rs2));
            check("tbl.funct3", 64'(out_funct3), 64'(vecs[i].funct3));
            check("tbl.funct7", 64'(out_funct7), 64'(vecs[i].instr[31:25]));
            check("tbl.fmt",    64'(out_fmt),    64'(vecs[i].fmt));
            check("tbl.imm",    64'(out_imm),    64'(vecs[i].imm));
`ifdef DECODE_ILLEGAL_EN
            check("tbl.illegal", 64'(out_illegal), 64'(vecs[i].ill_en));
`else
            check("tbl.illegal", 64'(out_illegal), 64'd0);
`endif
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("tbl.count0", 64'(count),     64'd0);
            check("tbl.empty",  64'(out_valid), 64'd0);
        end
        // Empty buffer keeps showing the last popped record.
        check("hold.pc",  64'(out_pc),  64'h1018);
        check("hold.fmt", 64'(out_fmt), 64'd7);

        // Backpressure: fill to DEPTH with out_ready low.
        for (int k = 0; k < DEPTH; k++) begin
            w_instr[k] = rand_instr();
            drive_push(w_instr[k], 32'h2000 + 32'(k * 4));
            exp_q.push_back(EW'(ref_decode(w_instr[k], 32'h2000 + 32'(k * 4))));
            @(negedge clk);
        end
        drive_push(32'h00500293, 32'h2FFC);  // must be refused while full
        check("bp.in_ready", 64'(in_ready), 64'd0);
        check("bp.count",    64'(count),    64'(DEPTH));
        check_head("bp.head0", exp_t'(exp_q[0]));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.count_hold", 64'(count), 64'(DEPTH));
        check_head("bp.head_stable", exp_t'(exp_q[0]));
        out_ready = 1'b1;
        while (exp_q.size() != 0) begin
            check_head("bp.drain", exp_t'(exp_q.pop_front()));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("bp.drained", 64'(count), 64'd0);
        check("bp.pc_hold", 64'(out_pc), 64'h200C);

        // Simultaneous push and pop at count=1.
        drive_push(32'h00100093, 32'h3000);
        @(negedge clk);
        drive_push(32'h00200113, 32'h3004);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("pp.count", 64'(count), 64'd1);
        check_head("pp.head", ref_decode(32'h00200113, 32'h3004));
        @(negedge clk);
        out_ready = 1'b0;
        check("pp.empty", 64'(count), 64'd0);

        // Flush with a same-cycle push: the pushed word is dropped.
        drive_push(32'h00300193, 32'h4000);
        @(negedge clk);
        drive_push(32'h00400213, 32'h4004);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fl.count", 64'(count),     64'd0);
        check("fl.valid", 64'(out_valid), 64'd0);
        drive_push(32'h00500293, 32'h4008);
        @(negedge clk);
        in_valid = 1'b0;
        check("fl.count1", 64'(count), 64'd1);
        check_head("fl.after", ref_decode(32'h00500293, 32'h4008));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset mid-stream.
        drive_push(32'h00600313, 32'h5000);
        @(negedge clk);
        drive_push(32'h00700393, 32'h5004);
        @(negedge clk);
        in_valid = 1'b0;
        check("rs.pre_count", 64'(count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rs.count",  64'(count),      64'd0);
        check("rs.valid",  64'(out_valid),  64'd0);
        check("rs.ready",  64'(in_ready),   64'd1);
        check("rs.pc",     64'(out_pc),     64'd0);
        check("rs.opcode", 64'(out_opcode), 64'd0);
        check("rs.imm",    64'(out_imm),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic against the queue model.
        exp_q.delete();
        last_shown = '0;
        for (int c = 0; c < 400; c++) begin
            logic do_push, do_pop, do_flush;
            logic [31:0] ri, rp;
            check("rnd.count",    64'(count),     64'(exp_q.size()));
            check("rnd.valid",    64'(out_valid), 64'(exp_q.size() != 0));
            check("rnd.in_ready", 64'(in_ready),  64'(exp_q.size() != DEPTH));
            if (exp_q.size() != 0) begin
                last_shown = exp_t'(exp_q[0]);
                check_head("rnd.head", last_shown);
            end else begin
                check("rnd.hold_pc",  64'(out_pc),  64'(last_shown.pc));
                check("rnd.hold_imm", 64'(out_imm), 64'(last_shown.imm));
            end
            ri = rand_instr();
            rp = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_instr  = ri;
            in_pc     = rp;
            do_push  = in_valid && (exp_q.size() != DEPTH);
            do_pop   = out_ready && (exp_q.size() != 0);
            do_flush = flush;
            if (do_flush) begin
                exp_q.delete();
            end else begin
                if (do_pop)  void'(exp_q.pop_front());
                if (do_push) exp_q.push_back(EW'(ref_decode(ri, rp)));
            end
            @(negedge clk);
        end
        drive_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
